// File: rtl/vram_arbiter.sv
// vram_arbiter: round-robin arbiter sharing one VRAM port between two requesters.
// Optional forced-completion timeout is enabled by defining VRAM_ARB_TIMEOUT_EN.
module vram_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset_i,

    input  logic        req0_sel_i,
    input  logic        req0_wr_i,
    input  logic [3:0]  req0_mask_i,
    input  logic [31:0] req0_addr_i,
    input  logic [15:0] req0_data_out_i,
    output logic        req0_ack_o,
    output logic        req0_err_o,
    output logic [15:0] req0_data_in_o,

    input  logic        req1_sel_i,
    input  logic        req1_wr_i,
    input  logic [3:0]  req1_mask_i,
    input  logic [31:0] req1_addr_i,
    input  logic [15:0] req1_data_out_i,
    output logic        req1_ack_o,
    output logic        req1_err_o,
    output logic [15:0] req1_data_in_o,

    output logic        vram_sel_o,
    output logic        vram_wr_o,
    output logic [3:0]  vram_mask_o,
    output logic [31:0] vram_addr_o,
    output logic [15:0] vram_data_out_o,
    input  logic        vram_ack_i,
    input  logic [15:0] vram_data_in_i,

    output logic [1:0]  grant_o,
    output logic        busy_o
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_sel;
    logic        r_wr;
    logic [3:0]  r_mask;
    logic [31:0] r_addr;
    logic [15:0] r_data;
    logic [1:0]  r_grant;
    logic        r_last;
    logic        w_pick1;
    logic        w_start;
    logic        w_done;
    logic        w_timeout;
    logic        w_busy;
    logic        w_ack;

    // r_last holds the index granted most recently; the other requester wins a tie.
    assign w_pick1 = req1_sel_i & (~req0_sel_i | ~r_last);
    assign w_busy  = (r_state == BUSY);
    assign w_ack   = (vram_ack_i | w_timeout) & w_busy;

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_state_next = r_state;
        w_start      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0_sel_i | req1_sel_i) begin
                    w_start      = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (vram_ack_i | w_timeout) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_sel   <= 1'b0;
            r_wr    <= 1'b0;
            r_mask  <= 4'h0;
            r_addr  <= 32'h0;
            r_data  <= 16'h0;
            r_grant <= 2'b00;
            r_last  <= 1'b1;
        end else if (w_start) begin
            r_sel   <= 1'b1;
            r_grant <= w_pick1 ? 2'b10 : 2'b01;
            r_wr    <= w_pick1 ? req1_wr_i       : req0_wr_i;
            r_mask  <= w_pick1 ? req1_mask_i     : req0_mask_i;
            r_addr  <= w_pick1 ? req1_addr_i     : req0_addr_i;
            r_data  <= w_pick1 ? req1_data_out_i : req0_data_out_i;
        end else if (w_done) begin
            r_sel   <= 1'b0;
            r_wr    <= 1'b0;
            r_grant <= 2'b00;
            r_last  <= r_grant[1];
        end
    end

`ifdef VRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (w_start) begin
            r_count <= '0;
        end else if (w_busy) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // r_count is zero in the first BUSY cycle, so TIMEOUT_CYCLES-1 marks the last allowed cycle.
    assign w_timeout = w_busy & ~vram_ack_i & (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    assign req0_ack_o      = w_ack & r_grant[0];
    assign req1_ack_o      = w_ack & r_grant[1];
    assign req0_err_o      = w_timeout & w_busy & r_grant[0];
    assign req1_err_o      = w_timeout & w_busy & r_grant[1];
    assign req0_data_in_o  = r_grant[0] ? vram_data_in_i : 16'h0;
    assign req1_data_in_o  = r_grant[1] ? vram_data_in_i : 16'h0;

    assign vram_sel_o      = r_sel;
    assign vram_wr_o       = r_wr;
    assign vram_mask_o     = r_mask;
    assign vram_addr_o     = r_addr;
    assign vram_data_out_o = r_data;
    assign grant_o         = r_grant;
    assign busy_o          = w_busy;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, giving the maximum cycles granted before a forced ack (used only with VRAM_ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port reset_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports reqN_sel_i  in  1  request from requester N (N=0,1).
REQ-005 SHALL have ports reqN_wr_i  in  1  write (1) / read (0).
REQ-006 SHALL have ports reqN_mask_i  in  4  byte mask.
REQ-007 SHALL have ports reqN_addr_i  in  32  word address.
REQ-008 SHALL have ports reqN_data_out_i  in  16  write data.
REQ-009 SHALL have ports reqN_ack_o  out  1  transaction done.
REQ-010 SHALL have ports reqN_err_o  out  1  transaction timed out.
REQ-011 SHALL have ports reqN_data_in_o  out  16  read data.
REQ-012 SHALL have VRAM ports vram_sel_o, vram_wr_o (out 1), vram_mask_o (out 4), vram_addr_o (out 32) and vram_data_out_o (out 16); vram_ack_i (in 1); vram_data_in_i (in 16).
REQ-013 SHALL have status ports grant_o  out  2  one-hot current owner (00 idle) and busy_o  out  1  transaction in flight.

Function
REQ-014 SHALL implement states IDLE and BUSY.
REQ-015 In IDLE with any reqN_sel_i=1, SHALL at the next edge latch the winner's wr/mask/addr/data onto vram_* outputs, assert vram_sel_o, set grant_o and busy_o, and enter BUSY (one-cycle request latency).
REQ-016 Arbitration SHALL be round-robin: a single requester wins immediately; on a tie, the requester not granted last wins; the last-granted pointer resets to 1, so req0 wins the first tie.
REQ-017 In BUSY, vram_* outputs SHALL stay constant; changes on the owner's inputs, including dropping sel, SHALL be ignored until completion.
REQ-018 reqN_ack_o SHALL equal vram_ack_i AND busy AND grant_o[N] (combinational); a non-owner's ack SHALL stay 0.
REQ-019 reqN_data_in_o SHALL equal vram_data_in_i when grant_o[N]=1, else 0.
REQ-020 On an edge with vram_ack_i=1 in BUSY, SHALL clear vram_sel_o, vram_wr_o, grant_o and busy_o, update the last-granted pointer and return to IDLE.
REQ-021 After completion, SHALL not grant again until the following edge, leaving a minimum of one cycle with vram_sel_o=0 between transactions.
REQ-022 vram_ack_i while IDLE SHALL be ignored.
REQ-023 A request raised in the same cycle as the current transaction's completion SHALL be evaluated at the next IDLE edge and SHALL not be lost while held high.

Reset
REQ-024 reset_i=1 SHALL immediately, without a clock, force IDLE, vram_sel_o=0, vram_wr_o=0, vram_mask_o=0, vram_addr_o=0, vram_data_out_o=0, grant_o=0, busy_o=0, last-granted=1 and timeout counter=0.
REQ-025 Reset mid-transaction SHALL abandon it with no ack or err to the requester; after release, arbitration SHALL restart from IDLE.

Configuration
REQ-026 With VRAM_ARB_TIMEOUT_EN defined, SHALL run a counter that clears on entry to BUSY and increments each BUSY cycle. If it reaches TIMEOUT_CYCLES with vram_ack_i=0, SHALL pulse reqN_ack_o=1 and reqN_err_o=1 to the owner for one cycle and complete as in REQ-020.
REQ-027 Without VRAM_ARB_TIMEOUT_EN, SHALL have no timeout counter, SHALL wait indefinitely for vram_ack_i, and SHALL tie reqN_err_o to 0.

Verification
REQ-028 req0 write addr=0x10, data=0x0F0F, vram_ack_i returned 3 cycles after vram_sel_o -> vram_sel_o high 1 cycle after req0_sel_i; vram_addr_o=0x10; req0_ack_o=1 for exactly that cycle; grant_o=01 then 00.
REQ-029 req0 and req1 both held high for 4 transactions -> grants alternate 0,1,0,1, with one sel-low cycle between each.
REQ-030 req1 read, vram_data_in_i=0xBEEF at ack -> req1_data_in_o=0xBEEF and req0_data_in_o=0 during ack.
REQ-031 reset_i pulsed mid-BUSY, between clock edges -> all vram_* outputs and grant_o go 0 before the next edge; no reqN_ack_o.
REQ-032 With VRAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, vram_ack_i held 0 -> req0_ack_o=1 and req0_err_o=1 on the 8th BUSY cycle, then IDLE. Without the macro -> still BUSY after 100 cycles.
